ras_stack: RTL

RAS_STACK -- requirements
Module: ras_stack

---
 rtl/ras_stack.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ras_stack.sv
`default_nettype none
// ============================================================================
// Module   : ras_stack
// Purpose  : Return-address stack for the fetch-side branch predictor.
//            Calls push (PC + 4), returns pop, coroutine ops replace the top
//            entry. A {cnt, tos} checkpoint travels with each branch so a
//            pipeline redirect can restore the speculative pointer state.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            ras_vld_i         - qualifies ras_ctrl_i / ras_data_i
//            ras_ctrl_i        - 00 none, 01 push, 10 pop, 11 pop-then-push
//            ras_data_i        - PC of the call instruction
//            flush_vld_i       - restore {cnt, tos} from ras_ckpt_i
//            ras_ckpt_i        - checkpoint {cnt, tos} to restore
//            ras_data_o        - predicted return target (0 when empty)
//            ras_empty_o       - entry count is zero
//            ras_ckpt_o        - current {cnt, tos}
//            ras_undf_o        - one-cycle pulse after a pop on empty stack
// Revision : 1.0 - initial release
// ============================================================================
module ras_stack #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ras_vld_i,
  input  logic [1:0]           ras_ctrl_i,
  input  logic [63:0]          ras_data_i,
  input  logic                 flush_vld_i,
  input  logic [2*PTR_W:0]     ras_ckpt_i,
  output logic [63:0]          ras_data_o,
  output logic                 ras_empty_o,
  output logic [2*PTR_W:0]     ras_ckpt_o,
  output logic                 ras_undf_o
);

  localparam logic [1:0]       c_OP_PUSH  = 2'b01;
  localparam logic [1:0]       c_OP_POP   = 2'b10;
  localparam logic [1:0]       c_OP_CORO  = 2'b11;
  localparam logic [PTR_W:0]   c_CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [63:0]      c_RET_OFS  = 64'h4;

  logic [63:0]      stk_q [DEPTH];
  logic [PTR_W-1:0] tos_q, tos_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             undf_q, undf_d;

  // Single array write port per cycle
  logic             w_wr_en;
  logic [PTR_W-1:0] w_wr_idx;
  logic [63:0]      w_wr_data;

  logic [PTR_W:0]   w_ckpt_cnt;
  logic [PTR_W-1:0] w_ckpt_tos;
  logic [PTR_W-1:0] w_tos_inc;
  logic [PTR_W-1:0] w_tos_dec;
  logic             w_empty;
  logic             w_full;

  assign w_ckpt_cnt = ras_ckpt_i[2*PTR_W:PTR_W];
  assign w_ckpt_tos = ras_ckpt_i[PTR_W-1:0];
  // PTR_W-bit arithmetic gives the modulo-DEPTH wrap for free
  assign w_tos_inc  = tos_q + PTR_W'(1);
  assign w_tos_dec  = tos_q - PTR_W'(1);
  assign w_empty    = (cnt_q == '0);
  assign w_full     = (cnt_q == c_CNT_FULL);

  always_comb begin
    tos_d     = tos_q;
    cnt_d     = cnt_q;
    undf_d    = 1'b0;
    w_wr_en   = 1'b0;
    w_wr_idx  = tos_q;
    w_wr_data = ras_data_i + c_RET_OFS;

    if (flush_vld_i) begin
      // Checkpoint counts beyond capacity are clamped to a full stack
      cnt_d = (w_ckpt_cnt > c_CNT_FULL) ? c_CNT_FULL : w_ckpt_cnt;
      tos_d = w_ckpt_tos;
    end else if (ras_vld_i) begin
      case (ras_ctrl_i)
        c_OP_PUSH: begin
          tos_d    = w_tos_inc;
          cnt_d    = w_full ? cnt_q : cnt_q + 1'b1;
          w_wr_en  = 1'b1;
          w_wr_idx = w_tos_inc;
        end
        c_OP_POP: begin
          if (w_empty) begin
            undf_d = 1'b1;
          end else begin
            tos_d = w_tos_dec;
            cnt_d = cnt_q - 1'b1;
          end
        end
        c_OP_CORO: begin
          if (w_empty) begin
            // Nothing to pop: degenerates to a plain push
            tos_d    = w_tos_inc;
            cnt_d    = cnt_q + 1'b1;
            w_wr_en  = 1'b1;
            w_wr_idx = w_tos_inc;
          end else begin
            w_wr_en  = 1'b1;
            w_wr_idx = tos_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tos_q  <= '0;
      cnt_q  <= '0;
      undf_q <= 1'b0;
    end else begin
      tos_q  <= tos_d;
      cnt_q  <= cnt_d;
      undf_q <= undf_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stk_q[i] <= '0;
      end
    end else if (w_wr_en) begin
      stk_q[w_wr_idx] <= w_wr_data;
    end
  end

  assign ras_data_o  = w_empty ? 64'h0 : stk_q[tos_q];
  assign ras_empty_o = w_empty;
  assign ras_ckpt_o  = {cnt_q, tos_q};
  assign ras_undf_o  = undf_q;

endmodule
`default_nettype wire
